// File: rtl/port_arbiter.sv
// Resolves ANY/LAST port operands into concrete directions for dir_manager, owns the LAST
// register and holds the core clock enable low until the resolved transfer completes.
module port_arbiter #(
  parameter int unsigned DATA_W = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] src,
  input  logic [2:0] dst,
  input  logic       op_valid,
  input  logic [3:0] in_valid,
  input  logic [3:0] out_ready,
  input  logic       mgr_clk_en,
  output logic [2:0] mgr_src,
  output logic [2:0] mgr_dst,
  output logic       clk_en_out,
  output logic [2:0] last_dir,
  output logic       busy
);

  localparam logic [2:0] TgtLeft  = 3'd0;
  localparam logic [2:0] TgtRight = 3'd1;
  localparam logic [2:0] TgtUp    = 3'd2;
  localparam logic [2:0] TgtDown  = 3'd3;
  localparam logic [2:0] TgtNil   = 3'd4;
  localparam logic [2:0] TgtAny   = 3'd6;
  localparam logic [2:0] TgtLast  = 3'd7;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSrc  = 2'd1;
  localparam logic [1:0] StDst  = 2'd2;
  localparam logic [1:0] StXfer = 2'd3;

  // Data width only travels alongside the bus; nothing here depends on it.
  if (DATA_W == 0) begin : g_data_w_unused
  end

  logic [1:0] state_q, state_d;
  logic       src_lock_vld_q, src_lock_vld_d;
  logic [2:0] src_lock_dir_q, src_lock_dir_d;
  logic       dst_lock_vld_q, dst_lock_vld_d;
  logic [2:0] dst_lock_dir_q, dst_lock_dir_d;
  logic [2:0] last_dir_q, last_dir_d;

  logic       src_ok, dst_ok, active, both_ok, complete;
  logic [2:0] src_res, dst_res;

  // Fixed ANY priority: LEFT > RIGHT > UP > DOWN.
  function automatic logic [2:0] prio_dir(input logic [3:0] req);
    if (req[0])      return TgtLeft;
    else if (req[1]) return TgtRight;
    else if (req[2]) return TgtUp;
    else             return TgtDown;
  endfunction

  always_comb begin
    src_ok  = 1'b1;
    src_res = src;
    if (src_lock_vld_q) begin
      src_res = src_lock_dir_q;
    end else if (src == TgtAny) begin
      src_ok  = |in_valid;
      src_res = src_ok ? prio_dir(in_valid) : TgtNil;
    end else if (src == TgtLast) begin
      src_res = last_dir_q;
    end

    dst_ok  = 1'b1;
    dst_res = dst;
    if (dst_lock_vld_q) begin
      dst_res = dst_lock_dir_q;
    end else if (dst == TgtAny) begin
      dst_ok  = |out_ready;
      dst_res = dst_ok ? prio_dir(out_ready) : TgtNil;
    end else if (dst == TgtLast) begin
      dst_res = last_dir_q;
    end
    // The destination is only considered once the source has resolved.
    dst_ok = dst_ok & src_ok;
  end

  assign active   = reset & (op_valid | (state_q != StIdle));
  assign both_ok  = active & src_ok & dst_ok;
  assign complete = both_ok & mgr_clk_en;

  assign mgr_src    = both_ok ? src_res : TgtNil;
  assign mgr_dst    = both_ok ? dst_res : TgtNil;
  assign clk_en_out = complete;
  assign last_dir   = last_dir_q;
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    src_lock_vld_d = src_lock_vld_q;
    src_lock_dir_d = src_lock_dir_q;
    dst_lock_vld_d = dst_lock_vld_q;
    dst_lock_dir_d = dst_lock_dir_q;
    last_dir_d     = last_dir_q;
    if (active) begin
      if (complete) begin
        state_d        = StIdle;
        src_lock_vld_d = 1'b0;
        dst_lock_vld_d = 1'b0;
        if (dst == TgtAny)      last_dir_d = dst_res;
        else if (src == TgtAny) last_dir_d = src_res;
      end else if (both_ok) begin
        state_d        = StXfer;
        src_lock_vld_d = 1'b1;
        src_lock_dir_d = src_res;
        dst_lock_vld_d = 1'b1;
        dst_lock_dir_d = dst_res;
      end else if (src_ok) begin
        state_d        = StDst;
        src_lock_vld_d = 1'b1;
        src_lock_dir_d = src_res;
      end else begin
        state_d = StSrc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      src_lock_vld_q <= 1'b0;
      src_lock_dir_q <= TgtNil;
      dst_lock_vld_q <= 1'b0;
      dst_lock_dir_q <= TgtNil;
      last_dir_q     <= TgtNil;
    end else begin
      state_q        <= state_d;
      src_lock_vld_q <= src_lock_vld_d;
      src_lock_dir_q <= src_lock_dir_d;
      dst_lock_vld_q <= dst_lock_vld_d;
      dst_lock_dir_q <= dst_lock_dir_d;
      last_dir_q     <= last_dir_d;
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed scenarios then random instructions, checked against an
// instruction-level model of operand resolution, locking and the LAST register.
module tb_port_arbiter;

  localparam logic [2:0] LEFT = 3'd0, RIGHT = 3'd1, UP = 3'd2, DOWN = 3'd3;
  localparam logic [2:0] NIL = 3'd4, ACC = 3'd5, ANY = 3'd6, LAST = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src, dst;
  logic       op_valid;
  logic [3:0] in_valid, out_ready;
  logic       mgr_clk_en;
  logic [2:0] mgr_src, mgr_dst, last_dir;
  logic       clk_en_out, busy;

  int n_vec = 0;
  int n_err = 0;

  // Model: what the pending instruction has already captured, plus the LAST register.
  logic       m_busy, m_sl, m_dl, m_done;
  logic [2:0] m_sd, m_dd, m_last;

  port_arbiter #(.DATA_W(11)) dut (
    .clk(clk), .reset(reset), .src(src), .dst(dst), .op_valid(op_valid),
    .in_valid(in_valid), .out_ready(out_ready), .mgr_clk_en(mgr_clk_en),
    .mgr_src(mgr_src), .mgr_dst(mgr_dst), .clk_en_out(clk_en_out),
    .last_dir(last_dir), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Neighbour bit i corresponds to direction i; lowest set bit wins.
  function automatic void resolve(input logic locked, input logic [2:0] lk, input logic [2:0] t,
                                  input logic [3:0] mask, output logic ok,
                                  output logic [2:0] dir);
    ok  = 1'b1;
    dir = t;
    if (locked) dir = lk;
    else if (t == ANY) begin
      ok  = 1'b0;
      dir = NIL;
      for (int i = 3; i >= 0; i--) if (mask[i]) begin ok = 1'b1; dir = 3'(i); end
    end else if (t == LAST) dir = m_last;
  endfunction

  // Compare outputs against the model for the current inputs, then advance one clock.
  task automatic cycle(input string tag);
    logic s_ok, d_ok, act, ok;
    logic [2:0] s_dir, d_dir;
    resolve(m_sl, m_sd, src, in_valid, s_ok, s_dir);
    resolve(m_dl, m_dd, dst, out_ready, d_ok, d_dir);
    act = reset && (op_valid || m_busy);
    ok  = act && s_ok && d_ok;
    chk({tag, ".mgr_src"}, 8'(mgr_src), 8'(ok ? s_dir : NIL));
    chk({tag, ".mgr_dst"}, 8'(mgr_dst), 8'(ok ? d_dir : NIL));
    chk({tag, ".clk_en"}, 8'(clk_en_out), 8'(ok && mgr_clk_en));
    chk({tag, ".busy"}, 8'(busy), 8'(m_busy));
    chk({tag, ".last"}, 8'(last_dir), 8'(m_last));
    @(posedge clk);
    m_done = 1'b0;
    if (!reset) begin
      m_busy = 0; m_sl = 0; m_dl = 0; m_last = NIL;
    end else if (ok && mgr_clk_en) begin
      m_done = 1'b1;
      if (dst == ANY) m_last = d_dir;
      else if (src == ANY) m_last = s_dir;
      m_busy = 0; m_sl = 0; m_dl = 0;
    end else if (act) begin
      m_busy = 1'b1;
      if (s_ok) begin m_sl = 1'b1; m_sd = s_dir; end
      if (ok) begin m_dl = 1'b1; m_dd = d_dir; end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] s, input logic [2:0] d, input logic ov,
                       input logic [3:0] iv, input logic [3:0] orr, input logic ce);
    src = s; dst = d; op_valid = ov; in_valid = iv; out_ready = orr; mgr_clk_en = ce;
    #1;
  endtask

  initial begin
    m_busy = 0; m_sl = 0; m_dl = 0; m_sd = NIL; m_dd = NIL; m_last = NIL; m_done = 0;
    reset = 1'b0;
    drive(NIL, NIL, 1'b0, 4'b0, 4'b0, 1'b0);
    @(negedge clk);
    #1;
    cycle("rst0");
    drive(ANY, ANY, 1'b1, 4'b1111, 4'b1111, 1'b1);
    chk("rst_hold_clk_en", 8'(clk_en_out), 8'd0);
    chk("rst_hold_src", 8'(mgr_src), 8'(NIL));
    cycle("rst1");
    reset = 1'b1;

    // ANY source with two neighbours offering
    drive(ANY, ACC, 1'b1, 4'b0110, 4'b0, 1'b0);
    chk("t1_src", 8'(mgr_src), 8'(RIGHT));
    cycle("t1a");
    drive(ANY, ACC, 1'b1, 4'b0, 4'b0, 1'b1);
    chk("t1_clk_en", 8'(clk_en_out), 8'd1);
    cycle("t1b");
    chk("t1_last", 8'(last_dir), 8'(RIGHT));

    // ANY source waiting, then a late DOWN that is dropped again
    drive(ANY, ACC, 1'b1, 4'b0, 4'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("t2wait");
    chk("t2_nil", 8'(mgr_src), 8'(NIL));
    chk("t2_busy", 8'(busy), 8'd1);
    drive(ANY, ACC, 1'b1, 4'b1000, 4'b0, 1'b0);
    chk("t2_down", 8'(mgr_src), 8'(DOWN));
    cycle("t2a");
    drive(ANY, ACC, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("t2_hold", 8'(mgr_src), 8'(DOWN));
    cycle("t2b");
    drive(ANY, ACC, 1'b1, 4'b0, 4'b0, 1'b1);
    cycle("t2c");

    // MOV ANY,ANY: source locks first, destination arrives later
    drive(ANY, ANY, 1'b1, 4'b0001, 4'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t3wait");
    chk("t3_dst_nil", 8'(mgr_dst), 8'(NIL));
    drive(ANY, ANY, 1'b1, 4'b0, 4'b0100, 1'b0);
    chk("t3_src", 8'(mgr_src), 8'(LEFT));
    chk("t3_dst", 8'(mgr_dst), 8'(UP));
    cycle("t3a");
    drive(ANY, ANY, 1'b1, 4'b0, 4'b0, 1'b1);
    cycle("t3b");
    chk("t3_last", 8'(last_dir), 8'(UP));

    // Explicit directions pass through and leave LAST alone
    drive(UP, LEFT, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("t6_src", 8'(mgr_src), 8'(UP));
    cycle("t6a");
    chk("t6_busy", 8'(busy), 8'd1);
    drive(UP, LEFT, 1'b1, 4'b0, 4'b0, 1'b1);
    cycle("t6b");
    chk("t6_last", 8'(last_dir), 8'(UP));

    // LAST after reset resolves to NIL, then follows an ANY write
    reset = 1'b0;
    drive(NIL, NIL, 1'b0, 4'b0, 4'b0, 1'b0);
    cycle("t4rst");
    reset = 1'b1;
    drive(LAST, ACC, 1'b1, 4'b0, 4'b0, 1'b1);
    chk("t4_nil", 8'(mgr_src), 8'(NIL));
    cycle("t4a");
    drive(ACC, ANY, 1'b1, 4'b0, 4'b1000, 1'b1);
    cycle("t4b");
    chk("t4_last_down", 8'(last_dir), 8'(DOWN));
    drive(LAST, ACC, 1'b1, 4'b0, 4'b0, 1'b1);
    chk("t4_src_down", 8'(mgr_src), 8'(DOWN));
    cycle("t4c");

    // Reset pulse while waiting on the destination
    drive(ANY, ANY, 1'b1, 4'b0001, 4'b0, 1'b0);
    cycle("t5a");
    reset = 1'b0;
    drive(ANY, ANY, 1'b1, 4'b0001, 4'b0, 1'b1);
    chk("t5_clk_en", 8'(clk_en_out), 8'd0);
    cycle("t5b");
    reset = 1'b1;
    drive(NIL, NIL, 1'b0, 4'b0, 4'b0, 1'b0);
    chk("t5_busy", 8'(busy), 8'd0);
    chk("t5_last", 8'(last_dir), 8'(NIL));
    cycle("t5c");

    // Random instructions with random neighbour traffic
    for (int n = 0; n < 600; n++) begin
      if (m_done) op_valid = 1'b0;
      if (!op_valid && !m_busy && $urandom_range(0, 2) != 0) begin
        src = 3'($urandom_range(0, 7));
        dst = 3'($urandom_range(0, 7));
        op_valid = 1'b1;
      end
      in_valid   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      out_ready  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      mgr_clk_en = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 59) != 0);
      #1;
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Resolves the ANY and LAST port operands of the current instruction into concrete directions before they reach `dir_manager`, and gates the core's clock enable until that resolution and the resulting transfer complete. It sits between the instruction decoder and `dir_manager` in each node. It owns the node's LAST register. It is the only block that decides which neighbour services an ANY operation.

## Interface
Parameters:
- `DATA_W`, 11, data width; unused internally, carried for bus consistency.

Ports:
- `clk`  in  1  node clock.
- `reset`  in  1  reset, synchronous, active-low.
- `src`  in  3  decoded source target: LEFT/RIGHT/UP/DOWN/NIL/ACC/ANY/LAST, using the shared target encoding.
- `dst`  in  3  decoded destination target, same encoding.
- `op_valid`  in  1  instruction present; held high until `clk_en_out` is high.
- `in_valid`  in  4  neighbour write-valid, bits {DOWN,UP,RIGHT,LEFT}.
- `out_ready`  in  4  neighbour read-ready, same bit order.
- `mgr_clk_en`  in  1  `clk_en` from `dir_manager`.
- `mgr_src`  out  3  resolved source to `dir_manager`.
- `mgr_dst`  out  3  resolved destination to `dir_manager`.
- `clk_en_out`  out  1  core advance enable.
- `last_dir`  out  3  LAST register.
- `busy`  out  1  high in S_SRC, S_DST or S_XFER.

## Operation
**Priority.** ANY uses fixed priority LEFT > RIGHT > UP > DOWN.

**State machine.** States are S_IDLE, S_SRC, S_DST and S_XFER. State registers are `src_lock` (valid + dir) and `dst_lock` (valid + dir).

**Source resolution (combinational each cycle):**
- If `src_lock` is valid, the resolved source is the locked direction.
- If `src` is ANY, the resolved source is the highest-priority set bit of `in_valid`. If no bit is set, the source is unresolved.
- If `src` is LAST, the resolved source is `last_dir`. When `last_dir` is NIL, the source resolves to NIL.
- Any other target passes through unchanged.

**Destination resolution:**
- Same rules as the source, using `out_ready`.
- Evaluated only once the source is resolved. An ANY destination never locks while the source is unresolved.

**State transitions:**
- **S_IDLE:**
  - `op_valid` with both operands resolved → S_XFER in the same cycle. This is zero-latency: outputs are driven immediately.
  - Source unresolved → S_SRC.
  - Source resolved but destination unresolved → S_DST.
- **S_SRC:** stay until an `in_valid` bit sets. On that cycle, lock the source, then apply the S_IDLE destination rule.
- **S_DST:** stay until an `out_ready` bit sets. On that cycle, lock the destination → S_XFER.
- **S_XFER:**
  - `mgr_src`/`mgr_dst` carry the resolved values.
  - `clk_en_out = mgr_clk_en`.
  - When `mgr_clk_en` is high, clear both locks, update `last_dir`, and → S_IDLE.

**Outputs while an operand is unresolved:** `mgr_src` = `mgr_dst` = NIL and `clk_en_out` = 0. This prevents `dir_manager` side effects.

**Locks:** a lock holds even if the neighbour drops `in_valid` or `out_ready`. The lock is released only by completion or reset.

**LAST update, on completion only:**
- If `dst` was ANY, `last_dir` takes the resolved destination.
- Otherwise, if `src` was ANY, `last_dir` takes the resolved source.
- Otherwise `last_dir` is unchanged.
- Explicit directions never update `last_dir`.

**`op_valid` low in S_IDLE:** `mgr_src`/`mgr_dst` = NIL and `clk_en_out` = 0.

## Timing
**Reset (`reset`=0 at a clk edge):**
- State → S_IDLE.
- Locks cleared.
- `last_dir` = NIL.
- `busy` = 0.
- While reset is held: `clk_en_out` = 0, `mgr_src` = `mgr_dst` = NIL.

**Reset mid-operation:** drops both locks with no `last_dir` update. The instruction restarts from S_IDLE after reset is released.

**Latency:**
- Zero cycles from `op_valid` to driving resolved targets when all operands resolve immediately.
- Otherwise, the lock registers on the first edge where a request appears, and resolved targets are driven from that same cycle.

**Simultaneous events:**
- Multiple `in_valid` bits set: priority selects one; the others keep waiting.
- `in_valid` and `out_ready` both arriving in the cycle that MOV ANY,ANY starts: both resolve in that cycle.

**Output style:** all outputs except `last_dir`, `busy` and the state are combinational from state, locks and inputs.

## Test plan
- **ANY source, two neighbours ready:** `src`=ANY, `dst`=ACC, `in_valid`=4'b0110 → `mgr_src`=RIGHT same cycle. On `mgr_clk_en`: `clk_en_out`=1 and `last_dir`=RIGHT.
- **ANY source, no neighbour ready:** `src`=ANY, `in_valid`=0 for 5 cycles → `mgr_src`=NIL, `clk_en_out`=0, `busy`=1. Set `in_valid`=4'b1000 → `mgr_src`=DOWN. Drop `in_valid` next cycle → `mgr_src` stays DOWN until completion.
- **MOV ANY,ANY:** `in_valid`=4'b0001, `out_ready`=0 for 3 cycles → source locks LEFT and `mgr_dst`=NIL. Then `out_ready`=4'b0100 → `mgr_dst`=UP. On completion, `last_dir`=UP.
- **LAST after reset:** `src`=LAST after reset → `mgr_src`=NIL and completes. After an ANY write that resolves to DOWN, `src`=LAST → `mgr_src`=DOWN.
- **Reset mid-operation:** in S_DST with source locked to LEFT, pulse `reset`=0 for one cycle → S_IDLE, locks cleared, `last_dir`=NIL, `clk_en_out`=0.
- **Explicit directions:** `src`=UP, `dst`=LEFT → pass through unchanged with `busy` asserted in S_XFER. `last_dir` does not change after completion.
